// File: rtl/set_cmp_pipe.sv
// set_cmp_pipe: two-stage unsigned compare unit for set instructions.
// S1 registers the carry-based difference, S2 decodes and registers the result.
module set_cmp_pipe #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_func,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAGW-1:0]  out_tag,
    output logic             out_illegal
);

    localparam logic [2:0] F_SEQ = 3'd0;
    localparam logic [2:0] F_SNE = 3'd1;
    localparam logic [2:0] F_SLT = 3'd2;
    localparam logic [2:0] F_SGT = 3'd3;
    localparam logic [2:0] F_SLE = 3'd4;
    localparam logic [2:0] F_SGE = 3'd5;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_diff;
    logic             s1_cout;
    logic [2:0]       s1_func;
    logic [TAGW-1:0]  s1_tag;

    logic             s2_free;
    logic             s1_adv;
    logic             in_fire;
    logic             out_fire;
    logic [WIDTH:0]   sum;
    logic             zero;
    logic             res_bit;
    logic             res_ill;

    // Handshake chain; flush blocks acceptance for its whole cycle.
    assign s2_free  = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_free;
    assign in_ready = !flush && (!s1_valid || s1_adv);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // a - b as a + ~b + 1 in WIDTH+1 bits; the top bit is the carry (a >= b).
    assign sum = {1'b0, in_a} + {1'b0, ~in_b} + {{WIDTH{1'b0}}, 1'b1};

    // Decode the registered difference/carry into the set result.
    always_comb begin
        zero    = (s1_diff == '0);
        res_bit = 1'b0;
        res_ill = 1'b0;
        unique case (s1_func)
            F_SEQ:   res_bit = zero;
            F_SNE:   res_bit = !zero;
            F_SLT:   res_bit = !s1_cout;
            F_SGT:   res_bit = s1_cout && !zero;
            F_SLE:   res_bit = !s1_cout || zero;
            F_SGE:   res_bit = s1_cout;
            default: res_ill = 1'b1;
        endcase
    end

    // Stage 1: capture the subtraction on each accepted operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_diff  <= '0;
            s1_cout  <= 1'b0;
            s1_func  <= '0;
            s1_tag   <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_diff  <= sum[WIDTH-1:0];
            s1_cout  <= sum[WIDTH];
            s1_func  <= in_func;
            s1_tag   <= in_tag;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: registered outputs, held while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s1_adv) begin
            out_valid   <= 1'b1;
            out_result  <= {{(WIDTH-1){1'b0}}, res_bit};
            out_tag     <= s1_tag;
            out_illegal <= res_ill;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_set_cmp_pipe.sv
// tb_set_cmp_pipe: directed self-checking bench for set_cmp_pipe.
// Expected values are hand-computed constants per vector.
module tb_set_cmp_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  in_func;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_tag;
    logic        out_illegal;

    int n_cmp;
    int n_err;

    logic [31:0] va [16];
    logic [31:0] vb [16];
    logic [2:0]  vf [16];
    logic        vr [16];
    logic        vi [16];

    set_cmp_pipe #(.WIDTH(32), .TAGW(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_func    (in_func),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_illegal(out_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] f,
                         input logic [4:0] t);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_func  = f;
        in_tag   = t;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] r,
                           input logic [4:0] t, input logic il);
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".result"}, 64'(out_result), 64'(r));
        chk({tag, ".tag"}, 64'(out_tag), 64'(t));
        chk({tag, ".illegal"}, 64'(out_illegal), 64'(il));
    endtask

    // Back-to-back stream with out_ready=1; result of op j at negedge j+2.
    task automatic run_stream(input string name, input int n, input int tb);
        for (int j = 0; j < n + 2; j++) begin
            @(negedge clk);
            if (j == 1)
                chk($sformatf("%s.lat", name), 64'(out_valid), 64'd0);
            if (j >= 2)
                chk_out($sformatf("%s[%0d]", name, j - 2), {31'd0, vr[j-2]},
                        5'(tb + j - 2), vi[j-2]);
            if (j < n) begin
                chk($sformatf("%s.rdy%0d", name, j), 64'(in_ready), 64'd1);
                drive(1'b1, va[j], vb[j], vf[j], 5'(tb + j));
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk($sformatf("%s.drain", name), 64'(out_valid), 64'd0);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 3'd0, 5'd0);

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst.valid", 64'(out_valid), 64'd0);
        chk("rst.result", 64'(out_result), 64'd0);
        chk("rst.tag", 64'(out_tag), 64'd0);
        chk("rst.illegal", 64'(out_illegal), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst.in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 6; i++) begin
            va[i] = 32'd5;
            vb[i] = 32'd5;
            vf[i] = 3'(i);
            va[i+6] = 32'd3;
            vb[i+6] = 32'd7;
            vf[i+6] = 3'(i);
            vi[i] = 1'b0;
            vi[i+6] = 1'b0;
        end
        vr[0] = 1; vr[1] = 0; vr[2] = 0;
        vr[3] = 0; vr[4] = 1; vr[5] = 1;
        vr[6] = 0; vr[7] = 1; vr[8] = 1;
        vr[9] = 0; vr[10] = 1; vr[11] = 0;
        run_stream("basic", 12, 0);

        va[0] = 32'hFFFF_FFFF; vb[0] = 32'h0; vf[0] = 3'd3;
        vr[0] = 1; vi[0] = 0;
        va[1] = 32'h0; vb[1] = 32'hFFFF_FFFF; vf[1] = 3'd2;
        vr[1] = 1; vi[1] = 0;
        va[2] = 32'h8000_0000; vb[2] = 32'h7FFF_FFFF; vf[2] = 3'd5;
        vr[2] = 1; vi[2] = 0;
        va[3] = 32'h7FFF_FFFF; vb[3] = 32'h8000_0000; vf[3] = 3'd5;
        vr[3] = 0; vi[3] = 0;
        va[4] = 32'd0; vb[4] = 32'd0; vf[4] = 3'd3;
        vr[4] = 0; vi[4] = 0;
        va[5] = 32'd4; vb[5] = 32'd4; vf[5] = 3'd6;
        vr[5] = 0; vi[5] = 1;
        va[6] = 32'd1; vb[6] = 32'd9; vf[6] = 3'd7;
        vr[6] = 0; vi[6] = 1;
        va[7] = 32'd1; vb[7] = 32'd2; vf[7] = 3'd2;
        vr[7] = 1; vi[7] = 0;
        run_stream("edge", 8, 16);

        // Back-pressure: out_ready low for five cycles.
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp.rdy0", 64'(in_ready), 64'd1);
        drive(1'b1, 32'd1, 32'd2, 3'd2, 5'd20);
        @(negedge clk);
        chk("bp.rdy1", 64'(in_ready), 64'd1);
        drive(1'b1, 32'd9, 32'd9, 3'd1, 5'd21);
        for (int k = 2; k < 5; k++) begin
            @(negedge clk);
            drive(1'b1, 32'd9, 32'd3, 3'd3, 5'd22);
            chk($sformatf("bp.rdy%0d", k), 64'(in_ready), 64'd0);
            chk_out($sformatf("bp.hold%0d", k), 32'd1, 5'd20, 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1 chk("bp.rdy5", 64'(in_ready), 64'd1);
        chk_out("bp.o0", 32'd1, 5'd20, 1'b0);
        @(negedge clk);
        chk_out("bp.o1", 32'd0, 5'd21, 1'b0);
        chk("bp.rdy6", 64'(in_ready), 64'd1);
        drive(1'b1, 32'd9, 32'd3, 3'd4, 5'd23);
        @(negedge clk);
        in_valid = 1'b0;
        chk_out("bp.o2", 32'd1, 5'd22, 1'b0);
        @(negedge clk);
        chk_out("bp.o3", 32'd0, 5'd23, 1'b0);
        @(negedge clk);
        chk("bp.drain", 64'(out_valid), 64'd0);

        // Flush with two ops in flight.
        drive(1'b1, 32'd5, 32'd5, 3'd0, 5'd5);
        @(negedge clk);
        drive(1'b1, 32'd3, 32'd7, 3'd2, 5'd6);
        @(negedge clk);
        flush = 1'b1;
        drive(1'b1, 32'd2, 32'd2, 3'd0, 5'd7);
        #1 chk("fl.in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        chk("fl.kill", 64'(out_valid), 64'd0);
        drive(1'b1, 32'd8, 32'd2, 3'd3, 5'd8);
        @(negedge clk);
        in_valid = 1'b0;
        chk("fl.gap", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk_out("fl.next", 32'd1, 5'd8, 1'b0);
        @(negedge clk);
        chk("fl.drain", 64'(out_valid), 64'd0);

        // Asynchronous reset with a result on the output.
        drive(1'b1, 32'd5, 32'd5, 3'd0, 5'd9);
        @(negedge clk);
        drive(1'b1, 32'd6, 32'd5, 3'd3, 5'd10);
        @(negedge clk);
        in_valid = 1'b0;
        chk_out("ar.pre", 32'd1, 5'd9, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar.valid", 64'(out_valid), 64'd0);
        chk("ar.result", 64'(out_result), 64'd0);
        chk("ar.tag", 64'(out_tag), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("ar.post%0d", k), 64'(out_valid), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
